// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: butterfly, DEPTH-entry feedback line, twiddle multiply.
// Define SDF_R2_ROUND_EN to round the twiddle product half-up instead of truncating.
module sdf_r2_stage #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int TW    = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic [AW-1:0]        tw_addr,
  input  logic signed [TW-1:0] tw_r,
  input  logic signed [TW-1:0] tw_i,
  output logic                 out_valid,
  output logic signed [DW+1:0] out_r,
  output logic signed [DW+1:0] out_i
);
  localparam int CW = $clog2(2 * DEPTH);
  localparam int SW = DW + 1;
  localparam int OW = DW + 2;
  localparam int MW = SW + TW;
  localparam int PW = MW + 1;
`ifdef SDF_R2_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW - 3);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  typedef struct packed {
    logic [SW-1:0] r;
    logic [SW-1:0] i;
  } cpx_t;

  typedef enum logic [1:0] {FILL, BFLY, TWID} st_t;

  st_t                  st, st_nxt;
  logic [CW-1:0]        cnt;
  logic [AW-1:0]        k;
  logic                 acc, last, produce;
  cpx_t                 dl [DEPTH];
  cpx_t                 dl_in;
  logic signed [SW-1:0] ar, ai, br, bi;
  logic signed [OW-1:0] sum_r, sum_i, prod_r, prod_i, nxt_r, nxt_i;
  logic signed [MW-1:0] prr, pii, pri, pir;
  logic signed [PW-1:0] re_full, im_full;

  assign acc = in_valid & ~clr;

  generate
    if (DEPTH == 1) begin : g_k1
      assign k = '0;
    end else begin : g_kn
      assign k = cnt[AW-1:0];
    end
  endgenerate

  assign last    = (k == AW'(DEPTH - 1));
  assign tw_addr = k;

  assign ar = {in_r[DW-1], in_r};
  assign ai = {in_i[DW-1], in_i};
  assign br = dl[DEPTH-1].r;
  assign bi = dl[DEPTH-1].i;

  assign sum_r = {br[SW-1], br} + {ar[SW-1], ar};
  assign sum_i = {bi[SW-1], bi} + {ai[SW-1], ai};

  // Full-precision complex product; |W|<=1 keeps the scaled result within OW bits.
  assign prr     = MW'(br) * MW'(tw_r);
  assign pii     = MW'(bi) * MW'(tw_i);
  assign pri     = MW'(br) * MW'(tw_i);
  assign pir     = MW'(bi) * MW'(tw_r);
  assign re_full = PW'(prr) - PW'(pii);
  assign im_full = PW'(pri) + PW'(pir);
  assign prod_r  = OW'((re_full + RND) >>> (TW - 2));
  assign prod_i  = OW'((im_full + RND) >>> (TW - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= FILL;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (clr) st_nxt = FILL;
    else if (acc && last) begin
      case (st)
        FILL:    st_nxt = BFLY;
        BFLY:    st_nxt = TWID;
        TWID:    st_nxt = BFLY;
        default: st_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    produce = 1'b0;
    nxt_r   = '0;
    nxt_i   = '0;
    dl_in.r = ar;
    dl_in.i = ai;
    case (st)
      BFLY: begin
        produce = acc;
        nxt_r   = sum_r;
        nxt_i   = sum_i;
        dl_in.r = br - ar;
        dl_in.i = bi - ai;
      end
      TWID: begin
        produce = acc;
        nxt_r   = prod_r;
        nxt_i   = prod_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (acc)    cnt <= cnt + CW'(1);
  end

  // Contents are only read DEPTH accepts after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (acc) begin
      dl[0] <= dl_in;
      for (int j = 1; j < DEPTH; j++) dl[j] <= dl[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      out_valid <= produce;
      if (produce) begin
        out_r <= nxt_r;
        out_i <= nxt_i;
      end
    end
  end
endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed bench for sdf_r2_stage: DEPTH=4 and DEPTH=1 instances, scoreboard queues per instance.
module tb_sdf_r2_stage;
  logic              clk = 1'b0;
  logic              rst_n, clr;
  logic              in_valid, in_valid1;
  logic signed [7:0] in_r, in_i, in_r1, in_i1;
  logic [1:0]        tw_addr;
  logic [0:0]        tw_addr1;
  logic signed [7:0] tw_r, tw_i;
  logic signed [7:0] tw_r1, tw_i1;
  logic              out_valid, out_valid1;
  logic signed [9:0] out_r, out_i, out_r1, out_i1;

  typedef struct {int r; int i;} exp_t;
  exp_t q0[$], q1[$];
  int npass = 0, nfail = 0, total = 0;
  int k0 = 0;

`ifdef SDF_R2_ROUND_EN
  localparam int TR[4] = '{-4, -3, 0, 3};
  localparam int TI[4] = '{0, 3, 4, 3};
  localparam int XR[4] = '{-255, -179, 0, 179};
`else
  localparam int TR[4] = '{-4, -3, 0, 2};
  localparam int TI[4] = '{0, 2, 4, 2};
  localparam int XR[4] = '{-255, -180, 0, 179};
`endif
  localparam int XI[4] = '{0, 179, 255, 179};

  always #5 clk = ~clk;

  sdf_r2_stage #(.DEPTH(4), .DW(8), .TW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .tw_addr(tw_addr), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i));

  sdf_r2_stage #(.DEPTH(1), .DW(8), .TW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid1), .in_r(in_r1), .in_i(in_i1),
    .tw_addr(tw_addr1), .tw_r(tw_r1), .tw_i(tw_i1),
    .out_valid(out_valid1), .out_r(out_r1), .out_i(out_i1));

  // W8^k ROM
  always_comb begin
    case (tw_addr)
      2'd0:    begin tw_r = 8'sd64;  tw_i = 8'sd0;   end
      2'd1:    begin tw_r = 8'sd45;  tw_i = -8'sd45; end
      2'd2:    begin tw_r = 8'sd0;   tw_i = -8'sd64; end
      default: begin tw_r = -8'sd45; tw_i = -8'sd45; end
    endcase
  end
  assign tw_r1 = 8'sd64;
  assign tw_i1 = 8'sd0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (out_valid) begin
      if (q0.size() == 0) chk("dut0_spurious_valid", int'(out_valid), 0);
      else begin
        e = q0.pop_front();
        chk("dut0_out_r", out_r, e.r);
        chk("dut0_out_i", out_i, e.i);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (out_valid1) begin
      if (q1.size() == 0) chk("dut1_spurious_valid", int'(out_valid1), 0);
      else begin
        e = q1.pop_front();
        chk("dut1_out_r", out_r1, e.r);
        chk("dut1_out_i", out_i1, e.i);
      end
    end
  end

  task automatic exp0(input int r, input int i);
    exp_t e; e.r = r; e.i = i; q0.push_back(e);
  endtask
  task automatic exp1(input int r, input int i);
    exp_t e; e.r = r; e.i = i; q1.push_back(e);
  endtask

  task automatic send0(input int r, input int i);
    @(negedge clk);
    chk("dut0_tw_addr", int'(tw_addr), k0);
    in_valid = 1'b1; in_r = 8'(r); in_i = 8'(i);
    k0 = (k0 + 1) % 4;
  endtask

  task automatic idle0();
    @(negedge clk);
    chk("dut0_tw_addr_hold", int'(tw_addr), k0);
    in_valid = 1'b0;
  endtask

  task automatic send1(input int r, input int i);
    @(negedge clk);
    chk("dut1_tw_addr", int'(tw_addr1), 0);
    in_valid1 = 1'b1; in_r1 = 8'(r); in_i1 = 8'(i);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (q0.size() + q1.size()) != 0; n++) @(negedge clk);
    chk("drain_bound", q0.size() + q1.size(), 0);
  endtask

  task automatic clr0();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_r = 8'sd99; in_i = 8'sd7;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    k0 = 0;
    chk("clr_tw_addr", int'(tw_addr), 0);
  endtask

  task automatic frame_std(input bit gaps);
    for (int s = 1; s <= 4; s++) begin send0(s, 0); if (gaps) idle0(); end
    for (int s = 5; s <= 8; s++) begin exp0(2*s - 4, 0); send0(s, 0); if (gaps) idle0(); end
    for (int k = 0; k < 4; k++) begin exp0(TR[k], TI[k]); send0(0, 0); if (gaps) idle0(); end
    for (int k = 0; k < 4; k++) begin exp0(0, 0); send0(0, 0); if (gaps) idle0(); end
    idle0();
    drain();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    in_valid = 1'b0; in_r = '0; in_i = '0;
    in_valid1 = 1'b0; in_r1 = '0; in_i1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_tw_addr", int'(tw_addr), 0);
    chk("rst_out_valid1", int'(out_valid1), 0);
    rst_n = 1'b1;

    // basic frame, then the same with a gap after every sample
    frame_std(1'b0);
    clr0();
    frame_std(1'b1);

    // extremes: sums -1, differences -255 through the twiddle path
    clr0();
    for (int s = 0; s < 4; s++) send0(-128, 0);
    for (int s = 0; s < 4; s++) begin exp0(-1, 0); send0(127, 0); end
    for (int k = 0; k < 4; k++) begin exp0(XR[k], XI[k]); send0(0, 0); end
    for (int k = 0; k < 4; k++) begin exp0(0, 0); send0(0, 0); end
    idle0();
    drain();

    // clr aborts a partial frame, and wins over in_valid
    clr0();
    for (int s = 1; s <= 6; s++) begin
      if (s > 4) exp0(2*s - 4, 0);
      send0(s, 0);
    end
    idle0();
    drain();
    clr0();
    frame_std(1'b0);

    // async reset in the middle of the twiddle half
    clr0();
    for (int s = 1; s <= 4; s++) send0(s, 0);
    for (int s = 5; s <= 8; s++) begin exp0(2*s - 4, 0); send0(s, 0); end
    for (int k = 0; k < 2; k++) begin exp0(TR[k], TI[k]); send0(0, 0); end
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_out_r", out_r, 0);
    chk("async_rst_out_i", out_i, 0);
    chk("async_rst_tw_addr", int'(tw_addr), 0);
    @(negedge clk);
    rst_n = 1'b1; k0 = 0;
    frame_std(1'b0);

    // DEPTH=1 stage
    send1(3, 1);
    exp1(8, -1);  send1(5, -2);
    exp1(-2, 3);  send1(0, 0);
    exp1(0, 0);   send1(0, 0);
    exp1(0, 0);   send1(-4, 7);
    exp1(-2, 10); send1(2, 3);
    exp1(-6, 4);  send1(0, 0);
    exp1(0, 0);   send1(0, 0);
    @(negedge clk);
    in_valid1 = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
